// File: rtl/seq_pkg.sv
// Shared types and constants for the program sequencer: the FSM state encoding
// and default program-counter width.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        LOAD_WAIT = 2'd2,
        DONE      = 2'd3
    } seq_state_t;

    localparam int PCW_DEFAULT = 10;
    localparam int CYCLE_CNT_W = 16;

endpackage

// File: rtl/seq_cycle_counter.sv
// Saturating cycle counter with synchronous clear; sticks at all-ones once reached.
module seq_cycle_counter
    import seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   inc,
    output logic [CYCLE_CNT_W-1:0] count
);

    localparam logic [CYCLE_CNT_W-1:0] CNT_ONE = CYCLE_CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: drives the instruction-memory address, inserts a one-cycle
// stall after loads and stops on halt. Define PROG_SEQUENCER_CYCLE_COUNT_EN to add CycleCount.
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int PCW = PCW_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Branch,
    input  logic [PCW-1:0]   Target,
    input  logic             IsLoad,
    input  logic             Halt,
    output logic [PCW-1:0]   ProgCtr,
    output logic             InstrValid,
    output logic             Stall,
    output logic             Done,
`ifdef PROG_SEQUENCER_CYCLE_COUNT_EN
    output logic [15:0]      CycleCount,
`endif
    output logic [1:0]       StateDbg
);

    // Handshake: Start is a level sampled on each rising Clk; one high cycle in
    // IDLE or DONE launches execution, it is ignored elsewhere and never acknowledged.
    localparam logic [PCW-1:0] PC_ONE = PCW'(1);

    seq_state_t state;

    assign StateDbg   = state;
    assign InstrValid = (state == RUN);
    assign Stall      = (state == LOAD_WAIT);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            ProgCtr <= '0;
            Done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ProgCtr <= '0;
                    Done    <= 1'b0;
                    if (Start) state <= RUN;
                end
                RUN: begin
                    if (Halt) begin
                        state <= DONE;
                        Done  <= 1'b1;
                    end else if (IsLoad) begin
                        state <= LOAD_WAIT;
                    end else if (Branch) begin
                        ProgCtr <= Target;
                    end else begin
                        ProgCtr <= ProgCtr + PC_ONE;
                    end
                end
                // Load data lands this cycle; the instruction after the load follows.
                LOAD_WAIT: begin
                    ProgCtr <= ProgCtr + PC_ONE;
                    state   <= RUN;
                end
                DONE: begin
                    if (Start) begin
                        Done    <= 1'b0;
                        ProgCtr <= '0;
                        state   <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PROG_SEQUENCER_CYCLE_COUNT_EN
    logic cnt_clear;
    logic cnt_inc;

    assign cnt_clear = Start && ((state == IDLE) || (state == DONE));
    assign cnt_inc   = (state == RUN) || (state == LOAD_WAIT);

    seq_cycle_counter u_cycle_counter (
        .clk   (Clk),
        .rst_n (Reset_n),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .count (CycleCount)
    );
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed testbench for prog_sequencer: linear sequence of steps with
// hand-computed expected values checked by immediate assertions.
module tb_prog_sequencer;
    import seq_pkg::*;

    localparam int PCW = 10;

    logic           Clk;
    logic           Reset_n;
    logic           Start;
    logic           Branch;
    logic [PCW-1:0] Target;
    logic           IsLoad;
    logic           Halt;
    logic [PCW-1:0] ProgCtr;
    logic           InstrValid;
    logic           Stall;
    logic           Done;
    logic [1:0]     StateDbg;
`ifdef PROG_SEQUENCER_CYCLE_COUNT_EN
    logic [15:0]    CycleCount;
`endif

    int n_cmp = 0;
    int n_err = 0;

    prog_sequencer #(.PCW(PCW)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .Branch     (Branch),
        .Target     (Target),
        .IsLoad     (IsLoad),
        .Halt       (Halt),
        .ProgCtr    (ProgCtr),
        .InstrValid (InstrValid),
        .Stall      (Stall),
        .Done       (Done),
`ifdef PROG_SEQUENCER_CYCLE_COUNT_EN
        .CycleCount (CycleCount),
`endif
        .StateDbg   (StateDbg)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_run(input string tag, input logic [31:0] pc);
        check({tag, " pc"}, 32'(ProgCtr), pc);
        check({tag, " valid"}, 32'(InstrValid), 32'd1);
        check({tag, " stall"}, 32'(Stall), 32'd0);
    endtask

    initial begin
        Reset_n = 1'b0;
        Start   = 1'b0;
        Branch  = 1'b0;
        Target  = '0;
        IsLoad  = 1'b0;
        Halt    = 1'b0;

        // Reset state, observed before any clock edge
        #3;
        check("rst pc", 32'(ProgCtr), 32'h0);
        check("rst valid", 32'(InstrValid), 32'd0);
        check("rst stall", 32'(Stall), 32'd0);
        check("rst done", 32'(Done), 32'd0);
        check("rst state", 32'(StateDbg), 32'(IDLE));
        tick();
        tick();
        Reset_n = 1'b1;
        tick();
        check("idle state", 32'(StateDbg), 32'(IDLE));
        check("idle valid", 32'(InstrValid), 32'd0);

        // Start then five sequential cycles
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check_run("start", 32'h0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_run("seq", 32'(i));
        end

        // Branch at pc 7
        tick();
        tick();
        check_run("pre branch", 32'h7);
        Branch = 1'b1;
        Target = 10'h120;
        tick();
        check_run("branch", 32'h120);

        // Back to 7, then Branch+IsLoad together: load wins
        Target = 10'h007;
        tick();
        check_run("back to 7", 32'h7);
        IsLoad = 1'b1;
        Target = 10'h055;
        tick();
        check("ld stall", 32'(Stall), 32'd1);
        check("ld valid", 32'(InstrValid), 32'd0);
        check("ld pc", 32'(ProgCtr), 32'h7);
        // Everything ignored in LOAD_WAIT
        Halt  = 1'b1;
        Start = 1'b1;
        tick();
        Branch = 1'b0;
        IsLoad = 1'b0;
        Halt   = 1'b0;
        check_run("after ld", 32'h8);
        check("after ld done", 32'(Done), 32'd0);

        // Start ignored in RUN
        tick();
        Start = 1'b0;
        check_run("start in run", 32'h9);

        // Wrap from all-ones
        Branch = 1'b1;
        Target = 10'h3FF;
        tick();
        Branch = 1'b0;
        check_run("at 3ff", 32'h3FF);
        tick();
        check_run("wrap", 32'h0);

        // Wrap out of LOAD_WAIT
        Branch = 1'b1;
        tick();
        Branch = 1'b0;
        IsLoad = 1'b1;
        tick();
        IsLoad = 1'b0;
        check("ld3ff stall", 32'(Stall), 32'd1);
        check("ld3ff pc", 32'(ProgCtr), 32'h3FF);
        tick();
        check_run("ld wrap", 32'h0);

        // Halt at 0x010
        Branch = 1'b1;
        Target = 10'h010;
        tick();
        Branch = 1'b0;
        check_run("at 010", 32'h10);
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        check("halt done", 32'(Done), 32'd1);
        check("halt pc", 32'(ProgCtr), 32'h10);
        check("halt valid", 32'(InstrValid), 32'd0);
        check("halt state", 32'(StateDbg), 32'(DONE));
        Branch = 1'b1;
        IsLoad = 1'b1;
        tick();
        Branch = 1'b0;
        IsLoad = 1'b0;
        check("done held", 32'(Done), 32'd1);
        check("done pc held", 32'(ProgCtr), 32'h10);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("restart done", 32'(Done), 32'd0);
        check_run("restart", 32'h0);

        // Asynchronous reset in the middle of LOAD_WAIT
        tick();
        check_run("pre ld rst", 32'h1);
        IsLoad = 1'b1;
        tick();
        IsLoad = 1'b0;
        check("pre rst stall", 32'(Stall), 32'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("arst pc", 32'(ProgCtr), 32'h0);
        check("arst stall", 32'(Stall), 32'd0);
        check("arst done", 32'(Done), 32'd0);
        check("arst valid", 32'(InstrValid), 32'd0);
        tick();
        check("arst hold pc", 32'(ProgCtr), 32'h0);
        check("arst hold state", 32'(StateDbg), 32'(IDLE));
        Reset_n = 1'b1;
        tick();
        check("post rst state", 32'(StateDbg), 32'(IDLE));

`ifdef PROG_SEQUENCER_CYCLE_COUNT_EN
        check("cnt idle", 32'(CycleCount), 32'd0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("cnt start", 32'(CycleCount), 32'd0);
        tick();
        tick();
        IsLoad = 1'b1;
        tick();
        IsLoad = 1'b0;
        tick();
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        check("cnt done", 32'(CycleCount), 32'd5);
        tick();
        tick();
        check("cnt held", 32'(CycleCount), 32'd5);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("cnt restart", 32'(CycleCount), 32'd0);
        for (int i = 0; i < 70000; i++) @(posedge Clk);
        #1;
        check("cnt sat", 32'(CycleCount), 32'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
